// File: rtl/lane_runner_pkg.sv
// Shared PS/2 constants, scan codes and decoder FSM states for the lane runner.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lane_runner_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam int         PAUSE_LEN = 7;

  // Set-2 scan codes; the arrows need an E0 prefix.
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Single-channel auto-repeat: tracks the last pressed key and ticks after DELAY, then every PERIOD.
// Latency: tick is combinational from registered count; the caller registers it (visible next cycle).
// Backpressure: none; load/cancel are one-cycle strobes that are always accepted.
module ps2_repeat_timer #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CW            = 25,
  parameter int IW            = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic          cancel,
  input  logic [IW-1:0] cancel_idx,
  output logic          tick,
  output logic [IW-1:0] tick_idx
);

  logic [CW-1:0] rpt_cnt;
  logic          rpt_en;
  logic [IW-1:0] target;
  logic          cancel_hit;

  // A break of the target on the tick cycle wins: the key is already up.
  assign cancel_hit = cancel && (cancel_idx == target);
  assign tick       = rpt_en && (rpt_cnt == CW'(1)) && !cancel_hit;
  assign tick_idx   = target;

  // Repeat channel: a new press retargets and restarts the delay, target break stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt <= '0;
      rpt_en  <= 1'b0;
      target  <= '0;
    end else if (load) begin
      rpt_cnt <= CW'(REPEAT_DELAY);
      rpt_en  <= (REPEAT_DELAY != 0);
      target  <= load_idx;
    end else if (cancel_hit) begin
      rpt_en  <= 1'b0;
    end else if (rpt_en) begin
      if (rpt_cnt == CW'(1)) begin
        rpt_cnt <= CW'(REPEAT_PERIOD);
      end else begin
        rpt_cnt <= rpt_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keymap_decoder.sv
// PS/2 byte stream to per-key held/press/release/fire state, plus Pause detect and prefix timeout.
// Latency: a byte accepted on cycle N shows on the outputs on cycle N+1; all outputs registered.
// Backpressure: none; every ps2_valid byte is consumed.
module ps2_keymap_decoder
  import lane_runner_pkg::*;
#(
  parameter int                      NUM_KEYS      = 4,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES     = {SC_D, SC_A, SC_RIGHT, SC_LEFT},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT       = 4'b0011,
  parameter int                      REPEAT_DELAY  = 25_000_000,
  parameter int                      REPEAT_PERIOD = 5_000_000,
  parameter int                      TIMEOUT       = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_fire,
  output logic                pause_press,
  output logic                unmapped
);

  localparam int CNT_MAX = max3(REPEAT_DELAY, REPEAT_PERIOD, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  ps2_state_t          state;
  logic [2:0]          skip_cnt;
  logic [CW-1:0]       idle_cnt;

  logic                ev_make;
  logic                ev_brk;
  logic                ev_ext;
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] rel_vec;
  logic [NUM_KEYS-1:0] tick_vec;
  logic [IW-1:0]       load_idx;
  logic [IW-1:0]       cancel_idx;
  logic                tick;
  logic [IW-1:0]       tick_idx;

  // Classify the incoming byte as a complete make or break given the prefix state.
  always_comb begin
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (ps2_valid) begin
      case (state)
        ST_IDLE:    ev_make = !(ps2_data inside {PS2_EXT, PS2_BRK, PS2_PAUSE});
        ST_EXT: begin
          ev_make = !(ps2_data inside {PS2_EXT, PS2_BRK, PS2_PAUSE});
          ev_ext  = 1'b1;
        end
        ST_BRK:     ev_brk = 1'b1;
        ST_EXT_BRK: begin
          ev_brk = 1'b1;
          ev_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table lookup; duplicate entries all respond, highest index drives the repeat channel.
  always_comb begin
    match      = '0;
    load_idx   = '0;
    cancel_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (ps2_data == KEY_CODES[8*i +: 8]) && (ev_ext == KEY_EXT[i]);
    end
    press_vec = ev_make ? (match & ~key_held) : '0;
    rel_vec   = ev_brk  ? (match &  key_held) : '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press_vec[i]) load_idx   = IW'(i);
      if (rel_vec[i])   cancel_idx = IW'(i);
    end
  end

  assign tick_vec = tick ? (NUM_KEYS'(1) << tick_idx) : '0;

  ps2_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CW           (CW),
    .IW           (IW)
  ) u_repeat (
    .clk       (clk),
    .reset     (reset),
    .load      (|press_vec),
    .load_idx  (load_idx),
    .cancel    (|rel_vec),
    .cancel_idx(cancel_idx),
    .tick      (tick),
    .tick_idx  (tick_idx)
  );

  // Prefix FSM: tracks E0/F0/E1 context and abandons a stalled prefix after TIMEOUT idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      idle_cnt <= '0;
    end else if (ps2_valid) begin
      idle_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (ps2_data == PS2_EXT) begin
            state <= ST_EXT;
          end else if (ps2_data == PS2_BRK) begin
            state <= ST_BRK;
          end else if (ps2_data == PS2_PAUSE) begin
            state    <= ST_SKIP;
            skip_cnt <= 3'(PAUSE_LEN);
          end
        end
        ST_EXT: begin
          if (ps2_data == PS2_BRK) begin
            state <= ST_EXT_BRK;
          end else if (!(ps2_data inside {PS2_EXT, PS2_PAUSE})) begin
            state <= ST_IDLE;
          end
        end
        ST_SKIP: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (idle_cnt == CW'(TIMEOUT - 1)) begin
        state    <= ST_IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  // Registered key state and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_fire    <= '0;
      pause_press <= 1'b0;
      unmapped    <= 1'b0;
    end else begin
      key_held    <= (key_held | press_vec) & ~rel_vec;
      key_press   <= press_vec;
      key_release <= rel_vec;
      key_fire    <= press_vec | tick_vec;
      pause_press <= ps2_valid && (state == ST_SKIP) && (skip_cnt == 3'd1);
      unmapped    <= (ev_make || ev_brk) && (match == '0);
    end
  end

endmodule
